// File: rtl/mac_feeder.sv
// mac_feeder: feeds operand beats into the MAC array, drains its pipelines and captures the result
module mac_feeder #(
  parameter int BATCH = 32,
  parameter int DATA_W = 8,
  parameter int RES_W = 24,
  parameter int LEN_W = 8,
  parameter int MAC_LAT = 4,
  parameter int TREE_LAT = 5
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [LEN_W-1:0] acc_len,
  output logic busy,
  input logic in_valid,
  output logic in_ready,
  input logic [BATCH*DATA_W-1:0] in_a,
  input logic [BATCH*DATA_W-1:0] in_b,
  output logic new_acc,
  output logic [BATCH*DATA_W-1:0] vec_a,
  output logic [BATCH*DATA_W-1:0] vec_b,
  input logic [BATCH*RES_W-1:0] vec_out,
  input logic [RES_W-1:0] sca_out,
  output logic res_valid,
  output logic [BATCH*RES_W-1:0] res_vec,
  output logic [RES_W-1:0] res_sca
);
  localparam int D = 1 + MAC_LAT + TREE_LAT;
  localparam int CW = $clog2(D + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state;
  logic [LEN_W-1:0] len, beat_cnt;
  logic [CW-1:0] drain_cnt;
  logic hs;
  always_comb hs = in_valid & in_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      in_ready <= 1'b0;
      new_acc <= 1'b0;
      res_valid <= 1'b0;
      vec_a <= '0;
      vec_b <= '0;
      res_vec <= '0;
      res_sca <= '0;
      len <= '0;
      beat_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      vec_a <= hs ? in_a : '0;
      vec_b <= hs ? in_b : '0;
      new_acc <= hs & (beat_cnt == '0);
      res_valid <= 1'b0;
      case (state)
        IDLE:
          if (busy) busy <= 1'b0;
          else if (start && acc_len != '0) begin
            state <= FEED;
            busy <= 1'b1;
            in_ready <= 1'b1;
            len <= acc_len;
            beat_cnt <= '0;
          end
        FEED:
          if (hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == len - 1'b1) begin
              state <= DRAIN;
              in_ready <= 1'b0;
              drain_cnt <= '0;
            end
          end
        DRAIN:
          if (drain_cnt == CW'(D - 1)) begin
            res_vec <= vec_out;
            res_sca <= sca_out;
            res_valid <= 1'b1;
            state <= IDLE;
          end else drain_cnt <= drain_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed bench for mac_feeder driving a behavioural MAC array and adder tree
module tb_mac_feeder;
  localparam int BATCH = 32, DATA_W = 8, RES_W = 24, LEN_W = 8, MAC_LAT = 4, TREE_LAT = 5;
  localparam int VW = BATCH * DATA_W, RW = BATCH * RES_W;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [LEN_W-1:0] acc_len = '0;
  logic [VW-1:0] in_a = '0, in_b = '0;
  logic busy, in_ready, new_acc, res_valid;
  logic [VW-1:0] vec_a, vec_b;
  logic [RW-1:0] vec_out, res_vec;
  logic [RES_W-1:0] sca_out, res_sca;
  int checks = 0, failures = 0;
  int cyc = 0, hs_cnt = 0, na_cnt = 0, rv_cnt = 0, last_hs_e = 0;
  int h0, n0, r0;
  mac_feeder #(.BATCH(BATCH), .DATA_W(DATA_W), .RES_W(RES_W), .LEN_W(LEN_W),
    .MAC_LAT(MAC_LAT), .TREE_LAT(TREE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .new_acc(new_acc), .vec_a(vec_a), .vec_b(vec_b), .vec_out(vec_out),
    .sca_out(sca_out), .res_valid(res_valid), .res_vec(res_vec), .res_sca(res_sca)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (in_valid & in_ready) begin
      hs_cnt <= hs_cnt + 1;
      last_hs_e <= cyc + 1;
    end
    if (new_acc) na_cnt <= na_cnt + 1;
    if (res_valid) rv_cnt <= rv_cnt + 1;
  end
  // MAC array: 3 operand stages + accumulator = MAC_LAT, then a TREE_LAT-deep summing pipe
  logic [VW-1:0] da [MAC_LAT-1], db [MAC_LAT-1];
  logic dn [MAC_LAT-1];
  logic signed [RES_W-1:0] acc [BATCH], prod [BATCH];
  logic signed [RES_W-1:0] tp [TREE_LAT], lane_sum;
  always_comb begin
    vec_out = '0;
    lane_sum = '0;
    for (int i = 0; i < BATCH; i++) begin
      prod[i] = RES_W'($signed(da[MAC_LAT-2][i*DATA_W +: DATA_W])) * RES_W'($signed(db[MAC_LAT-2][i*DATA_W +: DATA_W]));
      vec_out[i*RES_W +: RES_W] = acc[i];
      lane_sum = lane_sum + acc[i];
    end
    sca_out = tp[TREE_LAT-1];
  end
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < MAC_LAT - 1; i++) begin
        da[i] <= '0;
        db[i] <= '0;
        dn[i] <= 1'b0;
      end
      for (int i = 0; i < BATCH; i++) acc[i] <= '0;
      for (int i = 0; i < TREE_LAT; i++) tp[i] <= '0;
    end else begin
      da[0] <= vec_a;
      db[0] <= vec_b;
      dn[0] <= new_acc;
      for (int i = 1; i < MAC_LAT - 1; i++) begin
        da[i] <= da[i-1];
        db[i] <= db[i-1];
        dn[i] <= dn[i-1];
      end
      for (int i = 0; i < BATCH; i++) acc[i] <= (dn[MAC_LAT-2] ? '0 : acc[i]) + prod[i];
      tp[0] <= lane_sum;
      for (int i = 1; i < TREE_LAT; i++) tp[i] <= tp[i-1];
    end
  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int n);
    acc_len = LEN_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_res(input string tag);
    for (int k = 0; k < 40 && !res_valid; k++) step();
    chk({tag, "_rv"}, res_valid, 1);
    chk({tag, "_lat"}, cyc - last_hs_e, 10);
  endtask
  function automatic logic [VW-1:0] rep(input logic [DATA_W-1:0] v);
    return {BATCH{v}};
  endfunction
  function automatic logic [RW-1:0] rep_r(input logic [RES_W-1:0] v);
    return {BATCH{v}};
  endfunction
  function automatic logic [VW-1:0] lanes;
    logic [VW-1:0] r;
    for (int i = 0; i < BATCH; i++) r[i*DATA_W +: DATA_W] = DATA_W'(i);
    return r;
  endfunction
  function automatic logic [RW-1:0] lanes_r(input int m);
    logic [RW-1:0] r;
    for (int i = 0; i < BATCH; i++) r[i*RES_W +: RES_W] = RES_W'(i * m);
    return r;
  endfunction
  initial begin
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_new_acc", new_acc, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_vec_a", vec_a, 0);
    chk("rst_res_vec", res_vec, 0);
    chk("rst_res_sca", res_sca, 0);
    rst = 1'b0;
    step();
    // abort mid-feed with an asynchronous reset
    r0 = rv_cnt;
    go(8);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = rep(5);
    in_b = rep(1);
    repeat (3) step();
    chk("t1_vec_a", vec_a, rep(5));
    #2 rst = 1'b1;
    #1;
    chk("t1_async_busy", busy, 0);
    chk("t1_async_ready", in_ready, 0);
    chk("t1_async_vec_a", vec_a, 0);
    chk("t1_async_vec_b", vec_b, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("t1_no_res", rv_cnt - r0, 0);
    chk("t1_idle_busy", busy, 0);
    // single-beat job
    h0 = hs_cnt;
    go(1);
    in_valid = 1'b1;
    in_a = rep(2);
    in_b = rep(3);
    step();
    chk("t2_new_acc", new_acc, 1);
    chk("t2_vec_a", vec_a, rep(2));
    chk("t2_vec_b", vec_b, rep(3));
    chk("t2_ready_drop", in_ready, 0);
    wait_res("t2");
    chk("t2_res_vec", res_vec, rep_r(6));
    chk("t2_res_sca", res_sca, 192);
    chk("t2_busy_rv", busy, 1);
    chk("t2_beats", hs_cnt - h0, 1);
    step();
    chk("t2_rv_pulse", res_valid, 0);
    chk("t2_busy_fall", busy, 0);
    in_valid = 1'b0;
    // four beats with bubbles in between
    h0 = hs_cnt;
    n0 = na_cnt;
    go(4);
    in_a = lanes();
    in_b = rep(1);
    for (int k = 0; k < 8; k++) begin
      in_valid = (k % 2 == 0);
      step();
      chk($sformatf("t3_vec_a_%0d", k), vec_a, (k % 2 == 0) ? lanes() : '0);
      chk($sformatf("t3_new_acc_%0d", k), new_acc, k == 0);
    end
    in_valid = 1'b0;
    wait_res("t3");
    chk("t3_beats", hs_cnt - h0, 4);
    chk("t3_new_acc_cnt", na_cnt - n0, 1);
    chk("t3_res_vec", res_vec, lanes_r(4));
    chk("t3_res_sca", res_sca, 1984);
    step();
    // zero-length job is ignored
    r0 = rv_cnt;
    go(0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", in_ready, 0);
    repeat (15) step();
    chk("t4_no_res", rv_cnt - r0, 0);
    chk("t4_busy_late", busy, 0);
    // start held high and surplus beats offered
    h0 = hs_cnt;
    acc_len = 3;
    start = 1'b1;
    in_valid = 1'b1;
    in_a = rep(1);
    in_b = rep(1);
    step();
    chk("t5_busy", busy, 1);
    wait_res("t5a");
    chk("t5a_beats", hs_cnt - h0, 3);
    chk("t5a_res_sca", res_sca, 96);
    chk("t5a_res_vec", res_vec, rep_r(3));
    chk("t5a_ready_rv", in_ready, 0);
    step();
    chk("t5_busy_gap", busy, 0);
    chk("t5_beats_gap", hs_cnt - h0, 3);
    step();
    chk("t5_restart", busy, 1);
    start = 1'b0;
    wait_res("t5b");
    chk("t5b_beats", hs_cnt - h0, 6);
    chk("t5b_res_sca", res_sca, 96);
    in_valid = 1'b0;
    step();
    // back-to-back jobs, second restarts the accumulation
    go(2);
    in_valid = 1'b1;
    in_a = rep(1);
    in_b = rep(1);
    repeat (2) step();
    in_valid = 1'b0;
    wait_res("t6a");
    chk("t6a_res_sca", res_sca, 64);
    chk("t6a_res_vec", res_vec, rep_r(2));
    step();
    go(2);
    in_valid = 1'b1;
    in_a = rep(8'hFF);
    repeat (2) step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("t6_hold", res_vec, rep_r(2));
    wait_res("t6b");
    chk("t6b_res_sca", res_sca, 24'hFFFFC0);
    chk("t6b_res_vec", res_vec, rep_r(24'hFFFFFE));
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Sequencing front/back end for the MAC array.
- Accepts an accumulation job of ACC length, then pulls operand-vector beats from an upstream valid/ready stream and drives vec_a, vec_b and new_acc into the array.
- After the last beat it drains the MAC and adder-tree pipelines, then captures the per-lane accumulations and the inner-product scalar into a one-cycle result pulse.
- Sits between the operand buffers and the MAC array in the PE.

Parameters:
- BATCH, 32: lanes per vector.
- DATA_W, 8: operand width.
- RES_W, 24: accumulator/result width.
- LEN_W, 8: width of the job length field.
- MAC_LAT, 4: cycles from vec_a/vec_b/new_acc at the array input to the product being reflected in vec_out.
- TREE_LAT, 5: cycles from vec_out to sca_out.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job request pulse; sampled only in IDLE.
- acc_len  in  LEN_W  beats in the job; sampled with start.
- busy  out  1  high from job acceptance until the cycle after res_valid.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  feeder can accept a beat.
- in_a  in  BATCH*DATA_W  operand A vector, lane i at bits [i*DATA_W +: DATA_W].
- in_b  in  BATCH*DATA_W  operand B vector, same packing.
- new_acc  out  1  to MAC array; restarts accumulation.
- vec_a  out  BATCH*DATA_W  to MAC array.
- vec_b  out  BATCH*DATA_W  to MAC array.
- vec_out  in  BATCH*RES_W  per-lane accumulations from the MAC array.
- sca_out  in  RES_W  inner-product sum from the MAC array.
- res_valid  out  1  one-cycle result strobe.
- res_vec  out  BATCH*RES_W  captured vec_out.
- res_sca  out  RES_W  captured sca_out.

Behaviour:

Reset (asynchronous, rst high):
- State goes to IDLE.
- busy, in_ready, new_acc and res_valid are 0.
- vec_a, vec_b, res_vec and res_sca are all zero.
- Beat counter and drain counter are cleared.
- Reset asserted mid-job aborts the job; no res_valid is produced for it.

State machine: IDLE, FEED, DRAIN.

IDLE:
- in_ready=0.
- On start=1 with acc_len!=0: latch acc_len, go to FEED, busy=1 from the next cycle.
- start with acc_len=0 is ignored; busy stays 0.

FEED:
- in_ready=1.
- Handshake is in_valid & in_ready at a clock edge.
- Each accepted beat registers in_a/in_b into vec_a/vec_b, so operands appear at the array one cycle after the handshake.
- new_acc=1 is registered alongside the first beat of the job only.
- A cycle with no handshake registers vec_a=vec_b=0 and new_acc=0. This is a bubble: it adds zero and leaves the accumulation intact.
- When the acc_len-th beat handshakes, in_ready drops the next cycle and the state goes to DRAIN.
- Beat count is exact: a beat offered after the last one is not accepted.

DRAIN:
- in_ready=0; vec_a=vec_b=0 and new_acc=0 are held, so vec_out stays stable.
- Drain counter runs D = 1+MAC_LAT+TREE_LAT cycles, counted from the last-beat handshake edge.
- On expiry: res_vec<=vec_out and res_sca<=sca_out, res_valid=1 for exactly one cycle, state goes to IDLE.
- busy falls in the cycle after res_valid.

Result timing and hold:
- Last handshake at edge E gives res_valid high in the cycle following edge E+D. With defaults D=10.
- res_vec/res_sca hold their value until the next capture.

start handling:
- start while busy=1, including the res_valid cycle, is ignored, not queued.

Arithmetic:
- No arithmetic in this block; all data is passed through or captured unmodified.
- Width, saturation and wrap-around are those of the MAC array.

acc_len wrap-around:
- acc_len = 2^LEN_W-1 is the maximum job; there is no wrap to zero.

Test Plan:
1. rst pulsed asynchronously mid-cycle during FEED after 3 of 8 beats -> all outputs 0 immediately, state IDLE, no res_valid afterwards; next start accepted normally.
2. acc_len=1, beat with all lanes a=2, b=3, in_valid continuous -> new_acc=1 with vec_a=2 one cycle after the handshake; res_valid after 10 cycles; res_vec lanes=6, res_sca=192.
3. acc_len=4, lane i: a=i, b=1, in_valid toggling 1,0,1,0 -> exactly 4 handshakes; new_acc only on the first; bubbles show vec_a=0; res_vec lane i = 4i; res_sca = 4*496 = 1984.
4. start with acc_len=0 -> busy stays 0, in_ready stays 0, no res_valid.
5. start held high through a whole job, plus in_valid held high 2 beats past acc_len=3 -> the second job begins only after busy falls; the extra beats are not accepted during DRAIN.
6. Back-to-back jobs: acc_len=2 (all a=1, b=1) then acc_len=2 (all a=-1, b=1) -> first res_sca=64; the second job's new_acc discards the old sum and res_sca=-64 in two's complement; res_vec holds 2 until the second capture.
